ipsxe_floating_point_pipe_ctrl_v1_1: RTL and testbench

//  Handshake/control wrapper for a fixed-latency floating-point datapath. Joins NUM_CH operand

---
 rtl/ipsxe_floating_point_pipe_ctrl_v1_1.sv | 127 ++++++++++++
 tb/tb_ipsxe_floating_point_pipe_ctrl_v1_1.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxe_floating_point_pipe_ctrl_v1_1.sv
// Handshake and control wrapper for a fixed-latency floating-point datapath: operand join,
// clock-enable generation, in-flight tracking and a credit-protected result FIFO.
module ipsxe_floating_point_pipe_ctrl_v1_1 #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              i_aclk,
  input  logic              i_areset_n,
  input  logic              i_aclken,
  input  logic [NUM_CH-1:0] i_s_tvalid,
  output logic [NUM_CH-1:0] o_s_tready,
  output logic              o_in_fire,
  output logic              o_pipe_ce,
  input  logic [DATA_W-1:0] i_dp_result,
  output logic              o_m_tvalid,
  input  logic              i_m_tready,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic              o_areset_n,
  output logic              o_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [1:0]        rst_sync_q;
  logic              en;
  logic              in_fire;
  logic              credit_ok;
  logic              push;
  logic              pop;
  logic              load;
  logic              mem_nonempty;
  logic [AW:0]       mem_count;
  int unsigned       fifo_count;
  int unsigned       total;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];

  // Reset synchroniser: asserts asynchronously, releases after two clock edges.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign o_areset_n = rst_sync_q[1];
  assign en         = i_aclken & o_areset_n;
  assign o_pipe_ce  = en;

  assign mem_count    = wr_ptr_q - rd_ptr_q;
  assign mem_nonempty = (wr_ptr_q != rd_ptr_q);
  // The output register is a FIFO slot, so it counts toward occupancy and credit.
  assign fifo_count   = 32'(mem_count) + 32'(out_valid_q);
  assign total        = 32'(inflight_q) + fifo_count;
  assign credit_ok    = (total < FIFO_DEPTH);

  assign in_fire    = en & credit_ok & (&i_s_tvalid);
  assign o_s_tready = {NUM_CH{in_fire}};
  assign o_in_fire  = in_fire;

  assign push = en & vld_q[LATENCY-1];
  assign pop  = en & out_valid_q & i_m_tready;
  assign load = en & mem_nonempty & (~out_valid_q | i_m_tready);

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_fire;
    for (int unsigned i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({in_fire, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      vld_q       <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (!o_areset_n) begin
      vld_q       <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      // Head is refilled only when empty or being consumed, so tdata holds under back-pressure.
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= mem[rd_ptr_q[AW-1:0]];
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= i_dp_result;
  end

  assign o_m_tvalid = out_valid_q;
  assign o_m_tdata  = out_data_q;
  assign o_busy     = (inflight_q != '0) | out_valid_q | mem_nonempty;

  overflow_check: assert property (@(posedge i_aclk) disable iff (!o_areset_n)
    !(push && !pop && (fifo_count == FIFO_DEPTH)));

endmodule

// File: tb/tb_ipsxe_floating_point_pipe_ctrl_v1_1.sv
// Scoreboard bench: expected results are queued on each accepted beat and a negedge monitor
// compares them as the block delivers results. The datapath stand-in adds the two operands.
module tb_ipsxe_floating_point_pipe_ctrl_v1_1;

  localparam int unsigned LATENCY    = 4;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 8;

  logic              aclk = 1'b0;
  logic              areset_n;
  logic              aclken;
  logic [NUM_CH-1:0] s_tvalid;
  logic [NUM_CH-1:0] s_tready;
  logic              in_fire;
  logic              pipe_ce;
  logic [DATA_W-1:0] dp_result;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              areset_n_out;
  logic              busy;

  logic [31:0] op_a, op_b, exp_cur;
  logic [31:0] dp_pipe [LATENCY];
  logic [31:0] exp_q [$];
  logic [31:0] vec_a [8];
  logic [31:0] vec_b [8];
  logic [31:0] vec_e [8];

  int n_checks = 0;
  int n_fail   = 0;
  int fire_cnt = 0;
  int res_cnt  = 0;

  ipsxe_floating_point_pipe_ctrl_v1_1 #(
    .LATENCY    (LATENCY),
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_aclk      (aclk),
    .i_areset_n  (areset_n),
    .i_aclken    (aclken),
    .i_s_tvalid  (s_tvalid),
    .o_s_tready  (s_tready),
    .o_in_fire   (in_fire),
    .o_pipe_ce   (pipe_ce),
    .i_dp_result (dp_result),
    .o_m_tvalid  (m_tvalid),
    .i_m_tready  (m_tready),
    .o_m_tdata   (m_tdata),
    .o_areset_n  (areset_n_out),
    .o_busy      (busy)
  );

  always #5 aclk = ~aclk;

  // Datapath stand-in: loads on fire, advances only when the clock enable is high.
  always @(posedge aclk) begin
    if (pipe_ce) begin
      dp_pipe[0] <= in_fire ? (op_a + op_b) : 32'hDEAD_BEEF;
      for (int i = 1; i < LATENCY; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign dp_result = dp_pipe[LATENCY-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input int k);
    op_a    = vec_a[k];
    op_b    = vec_b[k];
    exp_cur = vec_e[k];
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 60) begin
      tick();
      c++;
    end
    check(name, 32'(c < 60), 32'd1);
  endtask

  // Monitor: compare on every edge that will consume a result, queue on every accepted beat.
  always @(negedge aclk) begin
    if (m_tvalid && m_tready && aclken) begin
      res_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, expected no result", m_tdata);
      end else begin
        check("result_data", m_tdata, exp_q.pop_front());
      end
    end
    if (in_fire) begin
      exp_q.push_back(exp_cur);
      fire_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    int f0;
    int r0;
    int t5_idx [3];

    vec_a[0] = 32'h3F80_0000; vec_b[0] = 32'h0000_0000; vec_e[0] = 32'h3F80_0000;
    vec_a[1] = 32'h4000_0000; vec_b[1] = 32'h0000_0001; vec_e[1] = 32'h4000_0001;
    vec_a[2] = 32'h1234_5678; vec_b[2] = 32'h1111_1111; vec_e[2] = 32'h2345_6789;
    vec_a[3] = 32'hFFFF_FFFF; vec_b[3] = 32'h0000_0001; vec_e[3] = 32'h0000_0000;
    vec_a[4] = 32'h0000_FFFF; vec_b[4] = 32'h0000_0001; vec_e[4] = 32'h0001_0000;
    vec_a[5] = 32'h7FFF_FFFF; vec_b[5] = 32'h0000_0001; vec_e[5] = 32'h8000_0000;
    vec_a[6] = 32'hC049_0FDB; vec_b[6] = 32'h0000_0000; vec_e[6] = 32'hC049_0FDB;
    vec_a[7] = 32'h0102_0304; vec_b[7] = 32'h1020_3040; vec_e[7] = 32'h1122_3344;
    t5_idx = '{1, 4, 7};

    areset_n = 1'b0;
    aclken   = 1'b1;
    s_tvalid = '0;
    m_tready = 1'b1;
    op_a     = '0;
    op_b     = '0;
    exp_cur  = '0;

    // T1: reset hold and synchronised release
    repeat (3) tick();
    s_tvalid = 2'b11;
    #1;
    check("rst_sync_out", 32'(areset_n_out), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_fire", 32'(in_fire), 32'd0);
    check("rst_pipe_ce", 32'(pipe_ce), 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    s_tvalid = '0;
    areset_n = 1'b1;
    tick();
    check("rst_release_edge1", 32'(areset_n_out), 32'd0);
    tick();
    check("rst_release_edge2", 32'(areset_n_out), 32'd1);
    check("pipe_ce_on", 32'(pipe_ce), 32'd1);

    // T2: single beat latency
    drive(0);
    s_tvalid = 2'b11;
    #1;
    check("t2_fire", 32'(in_fire), 32'd1);
    tick();
    s_tvalid = '0;
    check("t2_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!m_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_tdata", m_tdata, 32'h3F80_0000);
    tick();
    check("t2_idle", 32'(busy), 32'd0);

    // T3: back-pressure fills exactly FIFO_DEPTH credits
    m_tready = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      drive(k % 8);
      s_tvalid = 2'b11;
      #1;
      if (in_fire) k++;
      tick();
    end
    check("t3_fire_count", 32'(k), 32'd8);
    check("t3_tready_blocked", 32'(s_tready), 32'd0);
    check("t3_head_tvalid", 32'(m_tvalid), 32'd1);
    check("t3_head_tdata", m_tdata, vec_e[0]);
    s_tvalid = '0;
    r0 = res_cnt;
    m_tready = 1'b1;
    drain("t3_drain");
    check("t3_result_count", 32'(res_cnt - r0), 32'd8);

    // T4: join waits for every channel
    f0 = fire_cnt;
    drive(2);
    s_tvalid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t4_no_fire", 32'(in_fire), 32'd0);
      check("t4_tready_low", 32'(s_tready), 32'd0);
      tick();
    end
    s_tvalid = 2'b11;
    #1;
    check("t4_fire", 32'(in_fire), 32'd1);
    tick();
    s_tvalid = '0;
    drain("t4_drain");
    check("t4_fire_count", 32'(fire_cnt - f0), 32'd1);

    // T5: clock enable freezes the pipeline and the output
    m_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(t5_idx[c]);
      s_tvalid = 2'b11;
      #1;
      check("t5_fire", 32'(in_fire), 32'd1);
      tick();
    end
    s_tvalid = '0;
    aclken   = 1'b0;
    repeat (5) tick();
    check("t5_ce_low", 32'(pipe_ce), 32'd0);
    check("t5_frozen_tvalid", 32'(m_tvalid), 32'd0);
    check("t5_frozen_busy", 32'(busy), 32'd1);
    aclken = 1'b1;
    lat = 0;
    while (!m_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("t5_resume_latency", 32'(lat), 32'd3);
    aclken = 1'b0;
    tick();
    tick();
    check("t5_hold_tvalid", 32'(m_tvalid), 32'd1);
    check("t5_hold_tdata", m_tdata, vec_e[1]);
    aclken = 1'b1;
    drain("t5_drain");

    // T6: reset with beats in flight and in the FIFO
    m_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(c);
      s_tvalid = 2'b11;
      tick();
    end
    s_tvalid = '0;
    tick();
    check("t6_busy_before", 32'(busy), 32'd1);
    check("t6_tvalid_before", 32'(m_tvalid), 32'd1);
    areset_n = 1'b0;
    #1;
    check("t6_tvalid_cleared", 32'(m_tvalid), 32'd0);
    check("t6_busy_cleared", 32'(busy), 32'd0);
    check("t6_tdata_cleared", m_tdata, 32'd0);
    check("t6_sync_low", 32'(areset_n_out), 32'd0);
    exp_q.delete();
    r0 = res_cnt;
    tick();
    tick();
    areset_n = 1'b1;
    tick();
    tick();
    check("t6_sync_release", 32'(areset_n_out), 32'd1);
    m_tready = 1'b1;
    repeat (10) tick();
    check("t6_no_stale", 32'(res_cnt - r0), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    r0 = res_cnt;
    drive(6);
    s_tvalid = 2'b11;
    tick();
    s_tvalid = '0;
    drain("t6_recover_drain");
    check("t6_recover_count", 32'(res_cnt - r0), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
